pixel_packer_mono8: RTL and testbench
=====================================

# pixel_packer_mono8

Packs a stream of single Mono8 pixels, one per handshake, into 128-bit bursts of 16 pixels for the CustomLogic framegrabber's output side. It sits downstream of the hls4ml / crop_norm pixel stream and upstream of the 128-bit output AXI-Stream. It reverses pixel serialization: the first pixel received lands in the least-significant byte. It tracks frame position, zero-pads and marks the final partial burst, and flags end of frame.

## Interface
Parameters:
- OUT_ROWS, 20, rows per frame.
- OUT_COLS, 20, columns per frame. OUT_ROWS*OUT_COLS need not be a multiple of 16.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  begin one frame; accepted when ap_start && ap_ready.
- ap_ready  out  1  high only in IDLE.
- ap_idle  out  1  high only in IDLE.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  high only in PACK.
- s_axis_tdata  in  8  Mono8 pixel.
- m_axis_tvalid  out  1  high only in SEND.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  128  packed burst; byte k holds pixel k of the burst.
- m_axis_tkeep  out  16  one bit per valid byte.
- m_axis_tlast  out  1  last burst of frame.
- cnt_col  out  $clog2(OUT_COLS)  column of the next pixel to be accepted.
- cnt_row  out  $clog2(OUT_ROWS)  row of the next pixel to be accepted.

## Operation
FSM states: IDLE, PACK, SEND, DONE.
- IDLE: ap_ready=1, ap_idle=1. On ap_start → PACK.
- PACK: s_axis_tready=1.
  - Each input handshake writes s_axis_tdata into byte lane cnt_idx_in_burst, then increments cnt_idx_in_burst, cnt_idx_in_frame, and cnt_col/cnt_row.
  - cnt_col wraps at OUT_COLS-1. cnt_row increments on that wrap.
  - On the handshake where cnt_idx_in_burst==15 or cnt_idx_in_frame==OUT_ROWS*OUT_COLS-1 → SEND.
- SEND: m_axis_tvalid=1; tdata, tkeep and tlast are held stable until the handshake.
  - tkeep = (1<<n)-1, where n is the number of bytes written (n=16 gives all ones).
  - tlast=1 only on the frame's final burst.
  - On handshake: clear the burst buffer to zero and reset cnt_idx_in_burst to 0.
  - Then → DONE if the frame is complete, otherwise → PACK.
- DONE: single cycle with all handshake outputs 0. Clears cnt_idx_in_frame, cnt_col and cnt_row. → IDLE.

Boundary behaviour:
- Unwritten byte lanes of a partial burst are 0x00.
- ap_start outside IDLE is ignored.
- reset in any state: return to IDLE, clear buffer and all counters, and discard the partial burst. No output beat is produced for the aborted frame.
- Input beats offered while not in PACK are not accepted; s_axis_tready is 0 there.

## Timing
- Reset values: ap_ready=1, ap_idle=1, all other outputs 0.
- s_axis_tready rises the cycle after ap_start is accepted.
- m_axis_tvalid rises the cycle after the 16th (or final) input handshake.
- Minimum period is 17 cycles per full burst: 16 input cycles plus 1 output cycle. The block does not overlap input and output; no double buffering.
- Backpressure: while m_axis_tready=0, the block stays in SEND and s_axis_tready stays 0.
- cnt_col/cnt_row update on the clock edge after each input handshake.
- Counters are unsigned. cnt_idx_in_burst is 4 bits. cnt_idx_in_frame is $clog2(OUT_ROWS*OUT_COLS) bits.

## Structure
- The shared package holds:
  - PIXEL_W=8, PIXELS_PER_BURST=16, BURST_W=128.
  - The state enum type.
- Sub-module pixel_lane_register: 16×8-bit register with byte-lane write enable, index input and synchronous clear. It also generates tkeep from the count.
- FSM and counters live in the top module.

## Test plan
- OUT_ROWS=4, OUT_COLS=8, pixels 0x00..0x1F, no stalls:
  - Two beats: 0x0F0E…0100 then 0x1F1E…1110.
  - tkeep=0xFFFF on both; tlast only on beat 2.
  - ap_idle returns high 2 cycles after the last output handshake.
- OUT_ROWS=3, OUT_COLS=6, pixels 0..17:
  - Beat 2 tdata = 0x…00001110 with upper 14 bytes zero.
  - tkeep=0x0003, tlast=1.
- m_axis_tready held low for 5 cycles during SEND:
  - tvalid/tdata/tkeep stay stable and s_axis_tready stays 0.
  - The beat completes on the first cycle tready=1.
- s_axis_tvalid toggled randomly 50%:
  - Output beats identical to the no-stall case.
  - cnt_col/cnt_row sequence matches the pixel index mod/div OUT_COLS.
- Reset asserted after 7 pixels:
  - No output beat; block returns to IDLE.
  - The next frame's first beat starts with that frame's pixel 0 in byte 0.
- ap_start pulsed while in PACK: ignored; frame output unchanged.

Source files
------------

// File: rtl/pixel_packer_mono8_pkg.sv
// Shared widths and FSM state type for the Mono8 to 128-bit burst packer.
package pixel_packer_mono8_pkg;

    localparam int unsigned PIXEL_W          = 8;
    localparam int unsigned PIXELS_PER_BURST = 16;
    localparam int unsigned BURST_W          = PIXEL_W * PIXELS_PER_BURST;
    localparam int unsigned IDX_W            = $clog2(PIXELS_PER_BURST);
    localparam int unsigned CNT_W            = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pixel_packer_mono8_if.sv
// AXI-Stream style handshake bundle; the slave view carries only what a pixel sink consumes.
interface pixel_packer_mono8_if #(
    parameter int unsigned DATA_W = 8
) ();
    localparam int unsigned KEEP_W = (DATA_W + 7) / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, output tready);

endinterface

// File: rtl/pixel_packer_mono8_pixel_lane_register.sv
// 16 x 8-bit burst buffer with byte-lane writes, synchronous clear and tkeep from the fill count.
module pixel_lane_register
    import pixel_packer_mono8_pkg::*;
(
    input  logic                        clk,
    input  logic                        i_clr,
    input  logic                        i_wr_en,
    input  logic [IDX_W-1:0]            i_idx,
    input  logic [PIXEL_W-1:0]          i_data,
    output logic [BURST_W-1:0]          o_data,
    output logic [PIXELS_PER_BURST-1:0] o_keep
);

    logic [BURST_W-1:0] r_data;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_wr_en) begin
            r_data[i_idx*PIXEL_W +: PIXEL_W] <= i_data;
            r_count                          <= r_count + CNT_W'(1);
        end
    end

    // Thermometer mask: lane k is kept once more than k bytes have been written.
    always_comb begin
        o_keep = '0;
        for (int unsigned k = 0; k < PIXELS_PER_BURST; k++) begin
            o_keep[k] = (CNT_W'(k) < r_count);
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pixel_packer_mono8.sv
// Packs one Mono8 pixel per handshake into 128-bit bursts, first pixel in byte 0, with frame tracking.
module pixel_packer_mono8
    import pixel_packer_mono8_pkg::*;
#(
    parameter int unsigned OUT_ROWS = 20,
    parameter int unsigned OUT_COLS = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ap_start,
    output logic                        ap_ready,
    output logic                        ap_idle,
    pixel_packer_mono8_if.slave         s_axis,
    pixel_packer_mono8_if.master        m_axis,
    output logic [$clog2(OUT_COLS)-1:0] cnt_col,
    output logic [$clog2(OUT_ROWS)-1:0] cnt_row
);

    localparam int unsigned FRAME_N = OUT_ROWS * OUT_COLS;
    localparam int unsigned FW      = $clog2(FRAME_N);
    localparam int unsigned CW      = $clog2(OUT_COLS);
    localparam int unsigned RW      = $clog2(OUT_ROWS);
    localparam logic [FW-1:0]    LAST_IDX   = FW'(FRAME_N - 1);
    localparam logic [CW-1:0]    COL_LAST   = CW'(OUT_COLS - 1);
    localparam logic [IDX_W-1:0] BURST_LAST = IDX_W'(PIXELS_PER_BURST - 1);

    state_t                        r_state;
    state_t                        w_next_state;
    logic [IDX_W-1:0]              r_idx_in_burst;
    logic [FW-1:0]                 r_idx_in_frame;
    logic [CW-1:0]                 r_col;
    logic [RW-1:0]                 r_row;
    logic                          r_last;
    logic                          w_in_hs;
    logic                          w_out_hs;
    logic                          w_frame_end;
    logic                          w_burst_end;
    logic                          w_buf_clr;
    logic [BURST_W-1:0]            w_data;
    logic [PIXELS_PER_BURST-1:0]   w_keep;

    assign w_in_hs     = (r_state == ST_PACK) && s_axis.tvalid;
    assign w_out_hs    = (r_state == ST_SEND) && m_axis.tready;
    assign w_frame_end = (r_idx_in_frame == LAST_IDX);
    assign w_burst_end = (r_idx_in_burst == BURST_LAST) || w_frame_end;
    assign w_buf_clr   = reset || w_out_hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        ap_ready      = 1'b0;
        ap_idle       = 1'b0;
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ap_ready = 1'b1;
                ap_idle  = 1'b1;
                if (ap_start) w_next_state = ST_PACK;
            end
            ST_PACK: begin
                s_axis.tready = 1'b1;
                if (s_axis.tvalid && w_burst_end) w_next_state = ST_SEND;
            end
            ST_SEND: begin
                m_axis.tvalid = 1'b1;
                if (m_axis.tready) w_next_state = r_last ? ST_DONE : ST_PACK;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // r_last is latched on the burst-closing write so tlast is stable for the whole SEND phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx_in_burst <= '0;
            r_idx_in_frame <= '0;
            r_col          <= '0;
            r_row          <= '0;
            r_last         <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_idx_in_burst <= r_idx_in_burst + IDX_W'(1);
                r_idx_in_frame <= r_idx_in_frame + FW'(1);
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (w_burst_end) r_last <= w_frame_end;
            end
            if (w_out_hs) begin
                r_idx_in_burst <= '0;
                r_last         <= 1'b0;
            end
            if (r_state == ST_DONE) begin
                r_idx_in_frame <= '0;
                r_col          <= '0;
                r_row          <= '0;
            end
        end
    end

    pixel_lane_register u_lanes (
        .clk     (clk),
        .i_clr   (w_buf_clr),
        .i_wr_en (w_in_hs),
        .i_idx   (r_idx_in_burst),
        .i_data  (s_axis.tdata),
        .o_data  (w_data),
        .o_keep  (w_keep)
    );

    assign m_axis.tdata = w_data;
    assign m_axis.tkeep = w_keep;
    assign m_axis.tlast = r_last;
    assign cnt_col      = r_col;
    assign cnt_row      = r_row;

endmodule

// File: tb/tb_pixel_packer_mono8.sv
// Scoreboard bench for pixel_packer_mono8: a 4x8 frame instance and a 3x6 partial-burst instance.
module tb_pixel_packer_mono8;
    import pixel_packer_mono8_pkg::*;

    typedef struct packed {
        logic [BURST_W-1:0]          data;
        logic [PIXELS_PER_BURST-1:0] keep;
        logic                        last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ap_start;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       m_tready;
    logic       sel;
    int         total = 0;
    int         bad = 0;
    beat_t      exp_q[$];

    always #5 clk = ~clk;

    pixel_packer_mono8_if #(.DATA_W(8))   s_a ();
    pixel_packer_mono8_if #(.DATA_W(128)) m_a ();
    pixel_packer_mono8_if #(.DATA_W(8))   s_b ();
    pixel_packer_mono8_if #(.DATA_W(128)) m_b ();

    assign s_a.tvalid = s_tvalid;
    assign s_a.tdata  = s_tdata;
    assign s_a.tkeep  = '1;
    assign s_a.tlast  = 1'b0;
    assign m_a.tready = m_tready;
    assign s_b.tvalid = s_tvalid;
    assign s_b.tdata  = s_tdata;
    assign s_b.tkeep  = '1;
    assign s_b.tlast  = 1'b0;
    assign m_b.tready = m_tready;

    logic       ready_a, idle_a, ready_b, idle_b;
    logic [2:0] col_a, col_b;
    logic [1:0] row_a, row_b;

    pixel_packer_mono8 #(.OUT_ROWS(4), .OUT_COLS(8)) dut_a (
        .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ready_a), .ap_idle(idle_a),
        .s_axis(s_a), .m_axis(m_a), .cnt_col(col_a), .cnt_row(row_a)
    );

    pixel_packer_mono8 #(.OUT_ROWS(3), .OUT_COLS(6)) dut_b (
        .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ready_b), .ap_idle(idle_b),
        .s_axis(s_b), .m_axis(m_b), .cnt_col(col_b), .cnt_row(row_b)
    );

    logic         o_ready, o_idle, o_s_tready, o_m_tvalid, o_m_tlast;
    logic [127:0] o_m_tdata;
    logic [15:0]  o_m_tkeep;
    logic [2:0]   o_col;
    logic [1:0]   o_row;

    always_comb begin
        if (sel) begin
            o_ready = ready_b; o_idle = idle_b; o_s_tready = s_b.tready; o_m_tvalid = m_b.tvalid;
            o_m_tdata = m_b.tdata; o_m_tkeep = m_b.tkeep; o_m_tlast = m_b.tlast;
            o_col = col_b; o_row = row_b;
        end else begin
            o_ready = ready_a; o_idle = idle_a; o_s_tready = s_a.tready; o_m_tvalid = m_a.tvalid;
            o_m_tdata = m_a.tdata; o_m_tkeep = m_a.tkeep; o_m_tlast = m_a.tlast;
            o_col = col_a; o_row = row_a;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ap_start = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic start_frame();
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1) begin
            bad++; $display("FAIL start_ready got=%b want=1", o_ready);
        end
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        total++;
        if (o_s_tready !== 1'b1) begin
            bad++; $display("FAIL start_tready got=%b want=1", o_s_tready);
        end
    endtask

    // Drives n_send pixels (value base+index); model pushes expected beats as bursts close.
    task automatic drive_pixels(input int n_send, input int n_frame, input int cols,
                                input logic [7:0] base, input bit rand_valid);
        beat_t cur;
        int    idx = 0;
        int    cyc = 0;
        int    lane = 0;
        cur = '0;
        while (idx < n_send) begin
            @(negedge clk);
            cyc++;
            if (cyc > 2000) begin
                total++; bad++;
                $display("FAIL drive_timeout sent=%0d want=%0d", idx, n_send);
                break;
            end
            s_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_tdata  = base + 8'(idx);
            if (s_tvalid && o_s_tready) begin
                total++;
                if (o_col !== 3'(idx % cols) || o_row !== 2'(idx / cols)) begin
                    bad++;
                    $display("FAIL cnt pix=%0d col/row got=%0d/%0d want=%0d/%0d",
                             idx, o_col, o_row, idx % cols, idx / cols);
                end
                cur.data[lane*8 +: 8] = s_tdata;
                lane++;
                if (lane == 16 || idx == n_frame - 1) begin
                    cur.keep = 16'((17'd1 << lane) - 17'd1);
                    cur.last = (idx == n_frame - 1);
                    exp_q.push_back(cur);
                    cur  = '0;
                    lane = 0;
                end
                idx++;
            end
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic collect(input int nbeats, input int stall);
        for (int b = 0; b < nbeats; b++) begin
            int    cyc = 0;
            beat_t held, obs, expv;
            m_tready = !(stall > 0 && b == 0);
            do begin
                @(negedge clk);
                cyc++;
            end while (o_m_tvalid !== 1'b1 && cyc < 3000);
            if (o_m_tvalid !== 1'b1) begin
                total++; bad++;
                $display("FAIL beat_timeout beat=%0d tvalid got=%b want=1", b, o_m_tvalid);
                return;
            end
            held = {o_m_tdata, o_m_tkeep, o_m_tlast};
            for (int k = 0; k < stall && b == 0; k++) begin
                @(negedge clk);
                obs = {o_m_tdata, o_m_tkeep, o_m_tlast};
                total++;
                if (obs !== held || o_m_tvalid !== 1'b1 || o_s_tready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d tvalid/s_tready got=%b/%b want=1/0 beat got=%h want=%h",
                             k, o_m_tvalid, o_s_tready, obs, held);
                end
            end
            m_tready = 1'b1;
            obs = {o_m_tdata, o_m_tkeep, o_m_tlast};
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL beat_unexpected beat=%0d got=%h", b, obs);
            end else begin
                expv = exp_q.pop_front();
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL beat%0d data got=%h want=%h keep got=%h want=%h last got=%b want=%b",
                             b, obs.data, expv.data, obs.keep, expv.keep, obs.last, expv.last);
                end
            end
            @(negedge clk);
            total++;
            if (o_m_tvalid !== 1'b0) begin
                bad++; $display("FAIL beat_complete beat=%0d tvalid got=%b want=0", b, o_m_tvalid);
            end
            if (b == nbeats - 1) begin
                total++;
                if (o_idle !== 1'b0) begin
                    bad++; $display("FAIL done_idle got=%b want=0", o_idle);
                end
                @(negedge clk);
                total++;
                if (o_idle !== 1'b1) begin
                    bad++; $display("FAIL idle_return got=%b want=1", o_idle);
                end
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        total++;
        if ({o_ready, o_idle, o_s_tready, o_m_tvalid, o_m_tlast} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=11000",
                     {o_ready, o_idle, o_s_tready, o_m_tvalid, o_m_tlast});
        end
        total++;
        if ({o_m_tdata, o_m_tkeep, o_col, o_row} !== '0) begin
            bad++;
            $display("FAIL reset_data got tdata=%h tkeep=%h col=%0d row=%0d want all 0",
                     o_m_tdata, o_m_tkeep, o_col, o_row);
        end
    endtask

    task automatic test_full_frame();
        sel = 1'b0;
        do_reset();
        start_frame();
        fork
            drive_pixels(32, 32, 8, 8'h00, 1'b0);
            collect(2, 0);
        join
    endtask

    task automatic test_partial();
        sel = 1'b1;
        do_reset();
        start_frame();
        fork
            drive_pixels(18, 18, 6, 8'h00, 1'b0);
            collect(2, 0);
        join
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        do_reset();
        start_frame();
        fork
            drive_pixels(32, 32, 8, 8'h00, 1'b0);
            collect(2, 5);
        join
    endtask

    task automatic test_random_valid();
        sel = 1'b0;
        do_reset();
        start_frame();
        fork
            drive_pixels(32, 32, 8, 8'h00, 1'b1);
            collect(2, 0);
        join
    endtask

    task automatic test_reset_abort();
        sel = 1'b0;
        do_reset();
        start_frame();
        drive_pixels(7, 32, 8, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        total++;
        if (o_m_tvalid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL abort_no_beat tvalid got=%b want=0 queued=%0d", o_m_tvalid, exp_q.size());
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({o_idle, o_s_tready, o_col, o_row} !== {1'b1, 1'b0, 3'd0, 2'd0}) begin
            bad++;
            $display("FAIL abort_idle idle/tready/col/row got=%b/%b/%0d/%0d want=1/0/0/0",
                     o_idle, o_s_tready, o_col, o_row);
        end
        start_frame();
        fork
            drive_pixels(32, 32, 8, 8'h40, 1'b0);
            collect(2, 0);
        join
    endtask

    task automatic test_start_in_pack();
        sel = 1'b0;
        do_reset();
        start_frame();
        fork
            drive_pixels(32, 32, 8, 8'h20, 1'b0);
            collect(2, 0);
            begin
                repeat (5) @(negedge clk);
                ap_start = 1'b1;
                @(negedge clk);
                ap_start = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        total++;
        if (o_idle !== 1'b1 || o_s_tready !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored idle/tready got=%b/%b want=1/0", o_idle, o_s_tready);
        end
    endtask

    initial begin
        reset = 1'b1; ap_start = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b1; sel = 1'b0;
        test_reset();
        test_full_frame();
        test_partial();
        test_backpressure();
        test_random_valid();
        test_reset_abort();
        test_start_in_pack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
